// File: rtl/mips_pkg.sv
// Widths shared across the single-cycle MIPS datapath: register file,
// instruction memory and data memory all agree on these.
package mips_pkg;
    localparam int DATA_W      = 32;
    localparam int DMEM_ADDR_W = 7;
endpackage

// File: rtl/data_memory.sv
// 128 x 32 data memory for the MEM stage: synchronous write, combinational
// read, and a synchronous reset that loads mem[i] = i into every word.
module data_memory
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::DMEM_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset wins over a same-edge write, so a pending store is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(unsigned'(i));
            end
        end else if (MemWrite) begin
            mem_q[address] <= WriteData;
        end
    end

    // No write-through: during a read+write cycle the old word is shown
    // until the edge commits the store.
    always_comb begin
        ReadData = '0;
        if (MemRead && !reset) begin
            ReadData = mem_q[address];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected read values into a
// queue, a separate monitor samples ReadData and pops/compares.
module tb_data_memory;

    logic        clock;
    logic        reset;
    logic [6:0]  address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    data_memory dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    event sample_ev;

    // Monitor: the sample request marks when ReadData is meaningful.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL %s: sample with empty scoreboard", "scoreboard");
            end else begin
                e = exp_q.pop_front();
                chk_cnt++;
                if (ReadData === e.exp) pass_cnt++;
                else $display("FAIL %s: got %08h expected %08h", e.name, ReadData, e.exp);
            end
        end
    end

    // Inputs change at negedge; one full posedge is applied.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic expect_rd(input logic [6:0] a, input logic rd,
                             input logic [31:0] exp, input string name);
        exp_t e;
        address = a;
        MemRead = rd;
        e.exp   = exp;
        e.name  = name;
        exp_q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    task automatic write_word(input logic [6:0] a, input logic [31:0] d);
        address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        address   = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        WriteData = '0;
        @(negedge clock);
        expect_rd(7'd3, 1'b1, 32'h0, "rd_during_reset");
        tick();
        tick();
        expect_rd(7'd3, 1'b1, 32'h0, "rd_during_reset_2");
        reset = 1'b0;

        expect_rd(7'd0, 1'b1, 32'h0000_0000, "reset_pat_0");
        expect_rd(7'd1, 1'b1, 32'h0000_0001, "reset_pat_1");
        expect_rd(7'd4, 1'b1, 32'h0000_0004, "reset_pat_4");
        expect_rd(7'd100, 1'b1, 32'h0000_0064, "reset_pat_100");

        write_word(7'd2, 32'h0000_00AA);
        expect_rd(7'd2, 1'b1, 32'h0000_00AA, "wr_rd_2");
        expect_rd(7'd4, 1'b1, 32'h0000_0004, "untouched_4");

        expect_rd(7'd2, 1'b0, 32'h0, "rd_disabled");
        expect_rd(7'd2, 1'b1, 32'h0000_00AA, "rd_reenabled");

        // Read and write together: old word first, new word after the edge.
        address   = 7'd5;
        WriteData = 32'hDEAD_BEEF;
        MemWrite  = 1'b1;
        expect_rd(7'd5, 1'b1, 32'h0000_0005, "rw_before_edge");
        tick();
        MemWrite = 1'b0;
        expect_rd(7'd5, 1'b1, 32'hDEAD_BEEF, "rw_after_edge");

        write_word(7'd127, 32'h1234_5678);
        expect_rd(7'd127, 1'b1, 32'h1234_5678, "wr_127");
        reset     = 1'b1;
        MemWrite  = 1'b1;
        WriteData = 32'hFFFF_FFFF;
        expect_rd(7'd127, 1'b1, 32'h0, "rst_pri_high_pre");
        tick();
        expect_rd(7'd127, 1'b1, 32'h0, "rst_pri_high_post");
        reset    = 1'b0;
        MemWrite = 1'b0;
        expect_rd(7'd127, 1'b1, 32'h0000_007F, "rst_pri_127");
        expect_rd(7'd5, 1'b1, 32'h0000_0005, "rst_restores_5");
        expect_rd(7'd2, 1'b1, 32'h0000_0002, "rst_restores_2");

        write_word(7'd0,   32'hCAFE_0000);
        write_word(7'd127, 32'h0BAD_F00D);
        expect_rd(7'd0,   1'b1, 32'hCAFE_0000, "bound_0");
        expect_rd(7'd127, 1'b1, 32'h0BAD_F00D, "bound_127");
        expect_rd(7'd1,   1'b1, 32'h0000_0001, "neigh_1");
        expect_rd(7'd126, 1'b1, 32'h0000_007E, "neigh_126");

        write_word(7'd10, 32'h1111_1111);
        write_word(7'd10, 32'h2222_2222);
        expect_rd(7'd10, 1'b1, 32'h2222_2222, "last_write_wins");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
